sevenseg_reader: RTL
====================

SEVENSEG_READER -- requirements
Module: sevenseg_reader

Interface
REQ-001 Parameter STABLE_CYCLES, default 4, number of consecutive identical sampled cycles required before a digit pattern is accepted (legal range 1..255).
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 seg  input  7  active-low segment lines, bit0=a .. bit6=g.
REQ-005 an  input  4  active-low digit enables, bit n selects digit n.
REQ-006 clr  input  1  synchronous clear of valid, err and frame tracking.
REQ-007 digit0..digit3  output  4 each  last accepted BCD value per digit.
REQ-008 valid  output  4  bit n set once digit n holds an accepted value.
REQ-009 upd  output  1  one-cycle pulse on each accepted digit.
REQ-010 upd_idx  output  2  index of the digit accepted with upd.
REQ-011 frame  output  1  one-cycle pulse when all four digits have been accepted since the last frame or clear.
REQ-012 err  output  1  sticky flag for a stable, non-blank, undecodable pattern.

Function
REQ-013 seg and an shall be registered once (sample stage) before any evaluation; all latencies count from this register.
REQ-014 Decode table (seg, a in bit0): 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000; 1111111 = blank; anything else = invalid.
REQ-015 FSM states: IDLE, TRACK, HELD.
REQ-016 IDLE: entered whenever the sample does not have exactly one an bit low; no counting.
REQ-017 IDLE->TRACK when exactly one an bit is low; stability counter loads 1.
REQ-018 TRACK: counter increments (8-bit, saturating) each cycle the sample equals the previous sample; any change reloads 1 (or goes IDLE per REQ-016).
REQ-019 TRACK->HELD when counter reaches STABLE_CYCLES; on that cycle the decode is committed.
REQ-020 Commit of a digit value: write digitN, set valid[N], pulse upd with upd_idx=N, registered on the following edge.
REQ-021 Commit of blank: no output change, no upd; still enter HELD.
REQ-022 Commit of invalid: set err, no digit write, no upd; enter HELD.
REQ-023 HELD: no further commit while sample unchanged; any change -> TRACK (count 1) or IDLE.
REQ-024 A stable pattern held indefinitely shall produce exactly one upd.
REQ-025 Seen mask (4 bits) sets bit N on each upd; when the mask becomes 1111, frame pulses in the same cycle as that upd and the mask clears to 0000.
REQ-026 clr clears valid, err and seen mask; digit values retained; FSM unaffected; if clr and a commit coincide, clr wins for valid/err/mask and the digit write and upd still occur.
REQ-027 Re-accepting the same digit before the frame completes shall not affect frame.

Reset
REQ-028 reset: state=IDLE, counter=0, sample regs=all ones, digit0..3=0, valid=0000, upd=0, upd_idx=0, frame=0, err=0, seen mask=0000.
REQ-029 reset asserted mid-TRACK shall discard the partial count; no upd on the release cycle.
REQ-030 reset has priority over clr and all other inputs.

Structure
REQ-031 Shared package sevenseg_pkg: the ten segment pattern constants, the blank constant, the FSM state enum.
REQ-032 Sub-module seg_to_bcd: combinational seg -> {bcd[3:0], is_blank, is_invalid}; one instance.
REQ-033 Target 120-400 lines RTL total.

Verification
REQ-034 STABLE_CYCLES=4, an=1110, seg=0100100 held 10 cycles -> exactly one upd, upd_idx=0, digit0=2, valid=0001.
REQ-035 an=1101, seg=0010010 for 3 cycles then seg=1111001 for 6 cycles -> no commit of 5; digit1=1, one upd.
REQ-036 Scan digits 0..3 with 1,2,3,4 each for 5 cycles -> four upd pulses, frame on the fourth, valid=1111, seen mask cleared.
REQ-037 an=1011, seg=0101010 for 5 cycles -> err=1, no upd; clr -> err=0.
REQ-038 an=1100 (two low) with seg=0000000 for 20 cycles -> FSM stays IDLE, no upd, no err.
REQ-039 reset at cycle 2 of a TRACK on digit 3 -> all outputs at reset values, no upd until a fresh 4-cycle stable window.

Source files
------------

// File: rtl/sevenseg_pkg.sv
// Shared definitions for the seven-segment display reader: active-low
// segment patterns (a in bit 0), the tracking FSM states and a small
// saturating counter helper.
package sevenseg_pkg;

  localparam logic [6:0] SEG_0     = 7'b1000000;
  localparam logic [6:0] SEG_1     = 7'b1111001;
  localparam logic [6:0] SEG_2     = 7'b0100100;
  localparam logic [6:0] SEG_3     = 7'b0110000;
  localparam logic [6:0] SEG_4     = 7'b0011001;
  localparam logic [6:0] SEG_5     = 7'b0010010;
  localparam logic [6:0] SEG_6     = 7'b0000010;
  localparam logic [6:0] SEG_7     = 7'b1111000;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0010000;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_TRACK = 2'd1,
    ST_HELD  = 2'd2
  } state_t;

  // Increment an 8-bit count, sticking at 255.
  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    if (v == 8'hFF) begin
      return v;
    end else begin
      return v + 8'd1;
    end
  endfunction

endpackage

// File: rtl/sevenseg_reader_seg_to_bcd.sv
// Combinational decoder from an active-low segment pattern to BCD, with
// separate flags for a fully blank digit and an unrecognised pattern.
module seg_to_bcd
  import sevenseg_pkg::*;
(
  input  logic [6:0] seg,
  output logic [3:0] bcd,
  output logic       is_blank,
  output logic       is_invalid
);

  // Table lookup; anything not a digit or blank is flagged invalid.
  always_comb begin
    bcd        = 4'd0;
    is_blank   = 1'b0;
    is_invalid = 1'b0;
    case (seg)
      SEG_0:     bcd = 4'd0;
      SEG_1:     bcd = 4'd1;
      SEG_2:     bcd = 4'd2;
      SEG_3:     bcd = 4'd3;
      SEG_4:     bcd = 4'd4;
      SEG_5:     bcd = 4'd5;
      SEG_6:     bcd = 4'd6;
      SEG_7:     bcd = 4'd7;
      SEG_8:     bcd = 4'd8;
      SEG_9:     bcd = 4'd9;
      SEG_BLANK: is_blank = 1'b1;
      default:   is_invalid = 1'b1;
    endcase
  end

endmodule

// File: rtl/sevenseg_reader.sv
// Reads a multiplexed four-digit seven-segment display. The bus is sampled
// once, a digit is accepted only after its pattern has been stable for
// STABLE_CYCLES samples, and accepted digits are tracked to flag a frame.
module sevenseg_reader
  import sevenseg_pkg::*;
#(
  parameter int STABLE_CYCLES = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [6:0] seg,
  input  logic [3:0] an,
  input  logic       clr,
  output logic [3:0] digit0,
  output logic [3:0] digit1,
  output logic [3:0] digit2,
  output logic [3:0] digit3,
  output logic [3:0] valid,
  output logic       upd,
  output logic [1:0] upd_idx,
  output logic       frame,
  output logic       err
);

  localparam logic [7:0] STABLE_C = STABLE_CYCLES[7:0];

  logic [6:0] seg_r;
  logic [3:0] an_r;
  logic [6:0] prev_seg_r;
  logic [3:0] prev_an_r;
  state_t     state_r;
  state_t     state_nxt_s;
  logic [7:0] cnt_r;
  logic [7:0] cnt_nxt_s;
  logic [3:0] seen_r;

  logic       one_low_s;
  logic [1:0] idx_s;
  logic       same_s;
  logic       commit_s;
  logic [3:0] bcd_s;
  logic       blank_s;
  logic       invalid_s;

  logic       accept_s;
  logic [3:0] bit_s;
  logic [3:0] seen_or_s;
  logic       frame_s;
  logic [3:0] valid_nxt_s;
  logic       err_nxt_s;
  logic [3:0] seen_nxt_s;

  seg_to_bcd u_dec (
    .seg        (seg_r),
    .bcd        (bcd_s),
    .is_blank   (blank_s),
    .is_invalid (invalid_s)
  );

  // Sample stage plus a one-deep history used for the stability compare.
  always_ff @(posedge clk) begin
    if (reset) begin
      seg_r      <= 7'h7F;
      an_r       <= 4'hF;
      prev_seg_r <= 7'h7F;
      prev_an_r  <= 4'hF;
    end else begin
      seg_r      <= seg;
      an_r       <= an;
      prev_seg_r <= seg_r;
      prev_an_r  <= an_r;
    end
  end

  // Identify the single enabled digit; more or fewer than one low is idle.
  always_comb begin
    one_low_s = 1'b1;
    idx_s     = 2'd0;
    case (an_r)
      4'b1110: idx_s = 2'd0;
      4'b1101: idx_s = 2'd1;
      4'b1011: idx_s = 2'd2;
      4'b0111: idx_s = 2'd3;
      default: one_low_s = 1'b0;
    endcase
  end

  assign same_s = (seg_r == prev_seg_r) && (an_r == prev_an_r);

  // FSM state and stability counter registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= ST_IDLE;
      cnt_r   <= 8'd0;
    end else begin
      state_r <= state_nxt_s;
      cnt_r   <= cnt_nxt_s;
    end
  end

  // Next-state logic: count identical samples and commit once the count
  // reaches the threshold, then hold until the sample changes.
  always_comb begin
    state_nxt_s = state_r;
    cnt_nxt_s   = cnt_r;
    commit_s    = 1'b0;
    if (!one_low_s) begin
      state_nxt_s = ST_IDLE;
      cnt_nxt_s   = 8'd0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          state_nxt_s = ST_TRACK;
          cnt_nxt_s   = 8'd1;
        end
        ST_TRACK: begin
          state_nxt_s = ST_TRACK;
          if (same_s) begin
            cnt_nxt_s = sat_inc8(cnt_r);
          end else begin
            cnt_nxt_s = 8'd1;
          end
        end
        ST_HELD: begin
          if (same_s) begin
            state_nxt_s = ST_HELD;
          end else begin
            state_nxt_s = ST_TRACK;
            cnt_nxt_s   = 8'd1;
          end
        end
        default: begin
          state_nxt_s = ST_IDLE;
          cnt_nxt_s   = 8'd0;
        end
      endcase
    end
    // A threshold of one commits on the very first tracked sample.
    if ((state_nxt_s == ST_TRACK) && (cnt_nxt_s >= STABLE_C)) begin
      commit_s    = 1'b1;
      state_nxt_s = ST_HELD;
    end else begin
      commit_s    = 1'b0;
    end
  end

  // Commit side effects; clr overrides the flag updates but not the digit write.
  always_comb begin
    accept_s    = commit_s && !blank_s && !invalid_s;
    bit_s       = 4'b0001 << idx_s;
    seen_or_s   = seen_r;
    valid_nxt_s = valid;
    err_nxt_s   = err;
    frame_s     = 1'b0;
    if (accept_s) begin
      seen_or_s   = seen_r | bit_s;
      valid_nxt_s = valid | bit_s;
    end else begin
      seen_or_s   = seen_r;
    end
    if (commit_s && invalid_s) begin
      err_nxt_s = 1'b1;
    end else begin
      err_nxt_s = err;
    end
    if (accept_s && (seen_or_s == 4'hF)) begin
      frame_s    = 1'b1;
      seen_nxt_s = 4'h0;
    end else begin
      frame_s    = 1'b0;
      seen_nxt_s = seen_or_s;
    end
    if (clr) begin
      valid_nxt_s = 4'h0;
      err_nxt_s   = 1'b0;
      seen_nxt_s  = 4'h0;
      frame_s     = 1'b0;
    end else begin
      frame_s     = frame_s;
    end
  end

  // Registered outputs and the seen mask.
  always_ff @(posedge clk) begin
    if (reset) begin
      digit0  <= 4'd0;
      digit1  <= 4'd0;
      digit2  <= 4'd0;
      digit3  <= 4'd0;
      valid   <= 4'h0;
      upd     <= 1'b0;
      upd_idx <= 2'd0;
      frame   <= 1'b0;
      err     <= 1'b0;
      seen_r  <= 4'h0;
    end else begin
      valid  <= valid_nxt_s;
      err    <= err_nxt_s;
      seen_r <= seen_nxt_s;
      frame  <= frame_s;
      upd    <= accept_s;
      if (accept_s) begin
        upd_idx <= idx_s;
        case (idx_s)
          2'd0:    digit0 <= bcd_s;
          2'd1:    digit1 <= bcd_s;
          2'd2:    digit2 <= bcd_s;
          2'd3:    digit3 <= bcd_s;
          default: digit0 <= bcd_s;
        endcase
      end
    end
  end

endmodule
